// File: rtl/reset_sequencer_pkg.sv
// State encodings and counter sizing shared by the reset sequencer files.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET      = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_HOLD       = 3'd2,
        S_REL_SOC    = 3'd3,
        S_REL_PERIPH = 3'd4,
        S_RUN        = 3'd5
    } state_t;

    // Counters carry one spare bit above the largest terminal count so they can saturate.
    function automatic int cntWidth(input int maxVal);
        return $clog2(maxVal) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Multi-flop synchroniser for one asynchronous input, with an optional
// debounce filter that only follows the input after it has been stable.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit DEBOUNCE_EN     = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_out
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   w_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync = r_chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_EN) begin : g_debounce
            localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_debounced;

            // The counter only runs while the synchronised input disagrees with the filtered value.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_cnt       <= '0;
                    r_debounced <= 1'b0;
                end else if (w_sync == r_debounced) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_debounced <= w_sync;
                    r_cnt       <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign o_out = r_debounced;
        end else begin : g_bypass
            assign o_out = w_sync;
        end
    endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the MCU core and its peripherals, gated on a
// stable PLL lock and a debounced reset button.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn_n,
    input  logic               i_pll_locked,
    output logic               o_soc_reset,
    output logic               o_periph_resetn,
    output logic               o_ready,
    output logic [STATE_W-1:0] o_state
);

    localparam int CNT_W = cntWidth((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic             w_btnDebounced;
    logic             w_lockSync;
    logic             w_fault;
    state_t           r_state;
    logic             r_socReset;
    logic             r_periphResetn;
    logic             r_ready;
    logic [CNT_W-1:0] r_holdCnt;
    logic [CNT_W-1:0] r_gapCnt;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_EN     (1'b1)
    ) u_btnSync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_btn_n),
        .o_out   (w_btnDebounced)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_EN     (1'b0)
    ) u_lockSync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_pll_locked),
        .o_out   (w_lockSync)
    );

    assign w_fault = ~w_lockSync | ~w_btnDebounced;

    // A fault past S_WAIT_LOCK re-asserts both resets on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_RESET;
            r_socReset     <= 1'b1;
            r_periphResetn <= 1'b0;
            r_ready        <= 1'b0;
            r_holdCnt      <= '0;
            r_gapCnt       <= '0;
        end else if (w_fault && (r_state inside {S_HOLD, S_REL_SOC, S_REL_PERIPH, S_RUN})) begin
            r_state        <= S_WAIT_LOCK;
            r_socReset     <= 1'b1;
            r_periphResetn <= 1'b0;
            r_ready        <= 1'b0;
            r_holdCnt      <= '0;
            r_gapCnt       <= '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (!w_fault) begin
                        r_state   <= S_HOLD;
                        r_holdCnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_holdCnt == HOLD_LAST) begin
                        r_state    <= S_REL_SOC;
                        r_socReset <= 1'b0;
                        r_gapCnt   <= '0;
                    end else if (r_holdCnt != '1) begin
                        r_holdCnt <= r_holdCnt + CNT_W'(1);
                    end
                end
                S_REL_SOC: begin
                    if (r_gapCnt == GAP_LAST) begin
                        r_state        <= S_REL_PERIPH;
                        r_periphResetn <= 1'b1;
                    end else if (r_gapCnt != '1) begin
                        r_gapCnt <= r_gapCnt + CNT_W'(1);
                    end
                end
                S_REL_PERIPH: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state        <= S_RESET;
                    r_socReset     <= 1'b1;
                    r_periphResetn <= 1'b0;
                    r_ready        <= 1'b0;
                    r_holdCnt      <= '0;
                    r_gapCnt       <= '0;
                end
            endcase
        end
    end

    assign o_soc_reset     = r_socReset;
    assign o_periph_resetn = r_periphResetn;
    assign o_ready         = r_ready;
    assign o_state         = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues cycle-tagged expected outputs, a monitor
// compares them as the clock reaches each tagged cycle.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       soc;
        logic       pr;
        logic       rdy;
        string      name;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btnN;
    logic       pllLocked;
    logic       socReset;
    logic       periphResetn;
    logic       ready;
    logic [2:0] state;

    int      cyc     = 0;
    int      nChecks = 0;
    int      nPass   = 0;
    expect_t sb[$];
    expect_t monE;

    reset_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (16),
        .STAGE_GAP       (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_btn_n         (btnN),
        .i_pll_locked    (pllLocked),
        .o_soc_reset     (socReset),
        .o_periph_resetn (periphResetn),
        .o_ready         (ready),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input expect_t e);
        nChecks++;
        if (state === e.st && socReset === e.soc && periphResetn === e.pr && ready === e.rdy) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s @cyc %0d: got state=%0d soc=%b pr=%b rdy=%b, expected state=%0d soc=%b pr=%b rdy=%b",
                     e.name, cyc, state, socReset, periphResetn, ready, e.st, e.soc, e.pr, e.rdy);
        end
    endtask

    task automatic pushExp(input int c, input logic [2:0] st, input logic soc,
                           input logic pr, input logic rdy, input string name);
        expect_t e;
        e.cyc  = c;
        e.st   = st;
        e.soc  = soc;
        e.pr   = pr;
        e.rdy  = rdy;
        e.name = name;
        sb.push_back(e);
    endtask

    // Release sequence starting from the cycle the FSM enters S_HOLD.
    task automatic pushHoldSequence(input int h);
        pushExp(h,      S_HOLD,       1'b1, 1'b0, 1'b0, "holdEntry");
        pushExp(h + 15, S_HOLD,       1'b1, 1'b0, 1'b0, "holdLast");
        pushExp(h + 16, S_REL_SOC,    1'b0, 1'b0, 1'b0, "socRelease");
        pushExp(h + 19, S_REL_SOC,    1'b0, 1'b0, 1'b0, "gapLast");
        pushExp(h + 20, S_REL_PERIPH, 1'b0, 1'b1, 1'b0, "periphRelease");
        pushExp(h + 21, S_RUN,        1'b0, 1'b1, 1'b1, "runEntry");
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic btn, input logic lock, output int base);
        btnN      = btn;
        pllLocked = lock;
        base      = cyc;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            monE = sb.pop_front();
            checkOutput(monE);
        end
    end

    initial begin
        int      b;
        int      h;
        expect_t e;

        rst       = 1'b1;
        btnN      = 1'b1;
        pllLocked = 1'b1;
        pushExp(2, S_RESET, 1'b1, 1'b0, 1'b0, "resetHeld0");
        pushExp(4, S_RESET, 1'b1, 1'b0, 1'b0, "resetHeld1");

        // Power-up: release reset with lock and button already good.
        waitUntil(5);
        rst = 1'b0;
        b   = cyc;
        pushExp(b + 1,  S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "waitAfterReset");
        pushExp(b + 10, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "debounceSettle");
        pushHoldSequence(b + 11);

        // Short button bounce in S_RUN is filtered out.
        waitUntil(40);
        applyStimulus(1'b0, 1'b1, b);
        pushExp(b + 2,  S_RUN, 1'b0, 1'b1, 1'b1, "bounce0");
        pushExp(b + 6,  S_RUN, 1'b0, 1'b1, 1'b1, "bounce1");
        pushExp(b + 10, S_RUN, 1'b0, 1'b1, 1'b1, "bounce2");
        pushExp(b + 13, S_RUN, 1'b0, 1'b1, 1'b1, "bounce3");
        waitUntil(45);
        applyStimulus(1'b1, 1'b1, b);

        // Held button press, then release restarts the sequence.
        waitUntil(55);
        applyStimulus(1'b0, 1'b1, b);
        pushExp(b + 10, S_RUN,       1'b0, 1'b1, 1'b1, "pressBefore");
        pushExp(b + 11, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "pressAssert");
        waitUntil(70);
        applyStimulus(1'b1, 1'b1, b);
        pushExp(b + 5, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "releaseWait");
        pushHoldSequence(b + 11);

        // Lock loss in S_RUN, then a lock glitch at hold count 10.
        waitUntil(105);
        applyStimulus(1'b1, 1'b0, b);
        pushExp(b + 2, S_RUN,       1'b0, 1'b1, 1'b1, "lockLossBefore");
        pushExp(b + 3, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "lockLossRun");
        waitUntil(110);
        applyStimulus(1'b1, 1'b1, b);
        h = b + 3;
        pushExp(h,      S_HOLD, 1'b1, 1'b0, 1'b0, "glitchHoldEntry");
        pushExp(h + 10, S_HOLD, 1'b1, 1'b0, 1'b0, "glitchHold10");
        waitUntil(h + 10);
        applyStimulus(1'b1, 1'b0, b);
        pushExp(h + 12, S_HOLD,      1'b1, 1'b0, 1'b0, "glitchHold12");
        pushExp(h + 13, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "glitchAbort");
        waitUntil(h + 13);
        applyStimulus(1'b1, 1'b1, b);
        pushExp(h + 14, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "glitchWait0");
        pushExp(h + 15, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "glitchWait1");
        h = h + 16;
        pushExp(h,      S_HOLD,    1'b1, 1'b0, 1'b0, "restartHoldEntry");
        pushExp(h + 15, S_HOLD,    1'b1, 1'b0, 1'b0, "restartHoldLast");
        pushExp(h + 16, S_REL_SOC, 1'b0, 1'b0, 1'b0, "restartSocRelease");

        // Lock loss during S_REL_SOC.
        waitUntil(h + 16);
        applyStimulus(1'b1, 1'b0, b);
        pushExp(b + 2, S_REL_SOC,   1'b0, 1'b0, 1'b0, "relSocBefore");
        pushExp(b + 3, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "relSocAbort");
        waitUntil(b + 3);
        applyStimulus(1'b1, 1'b1, b);
        pushExp(b + 2, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "relockWait");
        pushHoldSequence(b + 3);

        // Asynchronous reset between clock edges while in S_RUN.
        waitUntil(175);
        #2;
        rst = 1'b1;
        #1;
        e.cyc  = cyc;
        e.st   = S_RESET;
        e.soc  = 1'b1;
        e.pr   = 1'b0;
        e.rdy  = 1'b0;
        e.name = "asyncReset";
        checkOutput(e);
        pushExp(177, S_RESET, 1'b1, 1'b0, 1'b0, "asyncResetHeld");
        waitUntil(178);
        rst = 1'b0;
        b   = cyc;
        pushExp(b + 1, S_WAIT_LOCK, 1'b1, 1'b0, 1'b0, "waitAfterAsync");
        pushHoldSequence(b + 11);

        waitUntil(215);
        nChecks++;
        if (sb.size() == 0) begin
            nPass++;
        end else begin
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
